qpmm_sched: RTL and testbench

QPMM_SCHED -- requirements
Module: qpmm_sched

---
 rtl/qpmm_pkg.sv | 25 ++
 rtl/qpmm_tag_pipe.sv | 52 +++++
 rtl/qpmm_sched.sv | 118 +++++++++++
 tb/tb_qpmm_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/qpmm_pkg.sv
// ============================================================================
// qpmm_pkg : shared constants and types for the QPMM operand scheduler
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package qpmm_pkg;

  localparam int QPMM_W      = 272;
  localparam int QPMM_ADDR_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [QPMM_ADDR_W-1:0] dst;
  } tag_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/qpmm_tag_pipe.sv
// ============================================================================
// qpmm_tag_pipe : DEPTH-stage {valid, dst} tracker with per-stage address match
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module qpmm_tag_pipe #(
  parameter int DEPTH  = 19,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic [ADDR_W-1:0] cmp_a,
  input  logic [ADDR_W-1:0] cmp_b,
  output logic [DEPTH-1:0]  match_a,
  output logic [DEPTH-1:0]  match_b,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_dst,
  output logic              pending
);

  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] dst [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dst[i] <= '0;
    end else begin
      vld    <= {vld[DEPTH-2:0], in_valid};
      dst[0] <= in_dst;
      for (int i = 1; i < DEPTH; i++) dst[i] <= dst[i-1];
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
      assign match_a[g] = vld[g] && (dst[g] == cmp_a);
      assign match_b[g] = vld[g] && (dst[g] == cmp_b);
    end
  endgenerate

  // Last stage is the entry writing back this cycle; pending covers the rest.
  assign out_valid = vld[DEPTH-1];
  assign out_dst   = dst[DEPTH-1];
  assign pending   = |vld[DEPTH-2:0];

endmodule

`default_nettype wire

// File: rtl/qpmm_sched.sv
// ============================================================================
// qpmm_sched : issues operand reads to the QPMM and schedules Z write-back
//              L = RAM_LAT + MUL_LAT + 1 cycles after each accepted command.
//              Define QPMM_SCHED_HAZARD_EN to stall commands reading an
//              in-flight destination.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module qpmm_sched
  import qpmm_pkg::*;
#(
  parameter int ADDR_W  = QPMM_ADDR_W,
  parameter int RAM_LAT = 2,
  parameter int MUL_LAT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_srca,
  input  logic [ADDR_W-1:0] cmd_srcb,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic [ADDR_W-1:0] ram0_addrb,
  output logic [ADDR_W-1:0] ram1_addrb,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_wea,
  output logic              done_valid,
  output logic [ADDR_W-1:0] done_dst,
  output logic              busy
);

  localparam int L = RAM_LAT + MUL_LAT + 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_STALL = ST_STALL;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept;
  logic              blocked;
  logic              hazard;
  logic [L-1:0]      match_a;
  logic [L-1:0]      match_b;
  logic              ret_valid;
  logic [ADDR_W-1:0] ret_dst;
  logic              pending;
  logic              wr;

  qpmm_tag_pipe #(
    .DEPTH  (L),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_dst    (cmd_dst),
    .cmp_a     (cmd_srca),
    .cmp_b     (cmd_srcb),
    .match_a   (match_a),
    .match_b   (match_b),
    .out_valid (ret_valid),
    .out_dst   (ret_dst),
    .pending   (pending)
  );

`ifdef QPMM_SCHED_HAZARD_EN
  // The retiring stage is included: its Z is not in RAM until after this edge.
  assign blocked = (|match_a) || (|match_b);
`else
  assign blocked = 1'b0;
  logic unused_match;
  assign unused_match = ^{match_a, match_b};
`endif

  assign cmd_ready = !rst && !blocked;
  assign accept    = cmd_valid && cmd_ready;
  assign hazard    = cmd_valid && blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram0_addrb <= '0;
      ram1_addrb <= '0;
    end else if (accept) begin
      ram0_addrb <= cmd_srca;
      ram1_addrb <= cmd_srcb;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN: begin
        if (hazard)                  state_nxt = S_STALL;
        else if (!pending && !accept) state_nxt = S_IDLE;
      end
      S_STALL: if (!hazard) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign wr         = ret_valid && !rst;
  assign ram_wea    = wr;
  assign ram_addra  = wr ? ret_dst : '0;
  assign done_valid = wr;
  assign done_dst   = wr ? ret_dst : '0;
  assign busy       = !rst && (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_qpmm_sched.sv
// ============================================================================
// tb_qpmm_sched : directed bench for qpmm_sched with a cycle-level queue model
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_qpmm_sched;

  localparam int L = 19;
`ifdef QPMM_SCHED_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0;
  logic       cmd_ready, ram_wea, done_valid, busy;
  logic [7:0] ram0_addrb, ram1_addrb, ram_addra, done_dst;

  qpmm_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst),
    .ram0_addrb(ram0_addrb), .ram1_addrb(ram1_addrb), .ram_addra(ram_addra),
    .ram_wea(ram_wea), .done_valid(done_valid), .done_dst(done_dst), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted command is in flight from its accept cycle through
  // accept+L-1, and its write-back is visible in that last cycle.
  typedef struct { int acc; logic [7:0] dst; } ent_t;
  ent_t       q[$];
  int         cyc = 0;
  int         last_acc = -1;
  logic [7:0] exp_a = '0, exp_b = '0;
  bit         stall_flag = 1'b0;
  bit         chk_en = 1'b0;
  bit         m_blk, m_acc, m_hz;

  function automatic bit blocked(input logic [7:0] a, input logic [7:0] b, input int c);
    bit r = 1'b0;
    foreach (q[i])
      if (c >= q[i].acc && c <= q[i].acc + L - 1 && (q[i].dst == a || q[i].dst == b)) r = 1'b1;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    m_blk = HAZ && blocked(cmd_srca, cmd_srcb, cyc);
    m_acc = cmd_valid && !rst && !m_blk;
    m_hz  = cmd_valid && !rst && m_blk;
    cyc++;
    if (rst) begin
      q.delete();
      exp_a = '0; exp_b = '0; stall_flag = 1'b0; chk_en = 1'b1;
    end else begin
      if (m_acc) begin
        q.push_back('{cyc, cmd_dst});
        exp_a = cmd_srca; exp_b = cmd_srcb; last_acc = cyc;
      end
      stall_flag = m_hz;
    end
    while (q.size() > 0 && q[0].acc + L - 1 < cyc) void'(q.pop_front());
  end

  logic       e_wea;
  logic [7:0] e_dst;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      e_wea = 1'b0; e_dst = '0;
      foreach (q[i]) if (q[i].acc + L - 1 == cyc && !rst) begin e_wea = 1'b1; e_dst = q[i].dst; end
      check("cmd_ready",  cmd_ready,  !rst && !(HAZ && blocked(cmd_srca, cmd_srcb, cyc)));
      check("ram_wea",    ram_wea,    e_wea);
      check("ram_addra",  ram_addra,  e_dst);
      check("done_valid", done_valid, e_wea);
      check("done_dst",   done_dst,   e_dst);
      check("busy",       busy,       !rst && (q.size() > 0 || stall_flag));
      check("ram0_addrb", ram0_addrb, exp_a);
      check("ram1_addrb", ram1_addrb, exp_b);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                      output int t, output int stalls);
    bit got = 1'b0;
    stalls = 0; t = -1;
    cmd_valid = 1'b1; cmd_srca = a; cmd_srcb = b; cmd_dst = d;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1; else stalls++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (got) t = last_acc;
    else begin checks++; errors++; $display("FAIL send_timeout: dst %0d never accepted", d); end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 60 && !idle; n++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin checks++; errors++; $display("FAIL idle_timeout: busy stuck high"); end
    @(posedge clk); #1;
  endtask

  int t1, t2, s1, s2, nb, wea_n, nw, bad;
  logic [7:0] wa;
  int   wn[10];
  logic [7:0] wv[10];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    check("busy_after_reset",  busy, 0);
    check("addrb_after_reset", ram0_addrb, 0);
    @(posedge clk); #1;

    // Single command: write 19 cycles after accept, busy for 19 cycles.
    send(8'd3, 8'd4, 8'd5, t1, s1);
    nb = 0; wea_n = 0; wa = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) nb++;
      if (ram_wea && wea_n == 0) begin wea_n = n; wa = ram_addra; end
      if (!busy) break;
    end
    check("single_latency", wea_n, 19);
    check("single_addra",   wa, 5);
    check("single_busy",    nb, 19);
    @(posedge clk); #1;

    // Ten back-to-back commands retire as ten consecutive writes.
    for (int i = 0; i < 10; i++) begin
      send(8'(100 + i), 8'(120 + i), 8'(10 + i), t2, s2);
      if (i == 0) t1 = t2;
    end
    check("b2b_accept_span", t2 - t1, 9);
    nw = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ram_wea && nw < 10) begin wn[nw] = n; wv[nw] = ram_addra; nw++; end
      if (!busy) break;
    end
    check("b2b_write_count", nw, 10);
    bad = 0;
    for (int i = 0; i < nw; i++)
      if (wv[i] != 8'(10 + i) || wn[i] != wn[0] + i) bad++;
    check("b2b_order_consecutive", bad, 0);
    @(posedge clk); #1;

    // RAW on dst 7: second command waits past the retire cycle when enabled.
    send(8'd0, 8'd1, 8'd7, t1, s1);
    send(8'd7, 8'd9, 8'd30, t2, s2);
    check("raw_accept_gap", t2 - t1, HAZ ? 20 : 1);
    check("raw_stall_cycles", s2, HAZ ? 19 : 0);
    wait_idle();

    // Offer srca=2 exactly on the retire cycle of dst 2.
    send(8'd0, 8'd1, 8'd2, t1, s1);
    repeat (18) @(posedge clk);
    #1;
    send(8'd2, 8'd9, 8'd40, t2, s2);
    check("retire_accept_gap", t2 - t1, HAZ ? 20 : 19);
    check("retire_stall_cycles", s2, HAZ ? 1 : 0);
    wait_idle();

    // Reset mid-flight discards all pending write-backs.
    for (int i = 0; i < 3; i++) send(8'(60 + i), 8'(70 + i), 8'(50 + i), t1, s1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_addrb0", ram0_addrb, 0);
    check("post_rst_addrb1", ram1_addrb, 0);
    nw = 0; nb = 0;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) @(negedge clk);
      if (ram_wea || done_valid) nw++;
      if (busy) nb++;
    end
    check("post_rst_writes", nw, 0);
    check("post_rst_busy",   nb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
